// File: rtl/axi4_lite_read_arbiter.sv
// Two-requester round-robin arbiter in front of a single AXI4-Lite read master.
// One read is in flight at a time. A WAIT-phase timeout completes the read with an error response.
module axi4_lite_read_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  output logic                  req1_ready,
  output logic                  rsp0_valid,
  output logic                  rsp0_err,
  output logic                  rsp1_valid,
  output logic                  rsp1_err,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  read_start,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic                  read_busy,
  input  logic [DATA_WIDTH-1:0] read_data
);

  // The counter only has to reach TIMEOUT_CYCLES-1, so it is sized for that value.
  localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned CNT_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CNT_LAST);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic                   last_q, last_d;
  logic                   id_q, id_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  rdata_d;
  logic                   start_d;
  logic [ADDR_WIDTH-1:0]  raddr_d;
  logic                   v0_d, v1_d, e0_d, e1_d;
  logic                   pick1;

  // Next-state, grant and registered-output staging
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    id_d       = id_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    rdata_d    = rsp_rdata;
    start_d    = 1'b0;
    raddr_d    = '0;
    v0_d       = 1'b0;
    v1_d       = 1'b0;
    e0_d       = 1'b0;
    e1_d       = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    pick1      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The ready strobe is combinational, so it is held low while reset is asserted.
        if (rst_n && !read_busy && (req0_valid || req1_valid)) begin
          pick1      = req1_valid && (!req0_valid || !last_q);
          req0_ready = !pick1;
          req1_ready = pick1;
          id_d       = pick1;
          last_d     = pick1;
          addr_d     = pick1 ? req1_addr : req0_addr;
          start_d    = 1'b1;
          raddr_d    = pick1 ? req1_addr : req0_addr;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (!read_busy) begin
          rdata_d = read_data;
          v0_d    = !id_q;
          v1_d    = id_q;
          state_d = RESP;
        end else if (TMO_EN && (cnt_q == CNT_MAX)) begin
          // Give up on the transaction; its late data will be dropped.
          rdata_d = '0;
          v0_d    = !id_q;
          v1_d    = id_q;
          e0_d    = !id_q;
          e1_d    = id_q;
          state_d = RESP;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      id_q       <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
      rsp_rdata  <= '0;
      read_start <= 1'b0;
      read_addr  <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_err   <= 1'b0;
      rsp1_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      rsp_rdata  <= rdata_d;
      read_start <= start_d;
      read_addr  <= raddr_d;
      rsp0_valid <= v0_d;
      rsp1_valid <= v1_d;
      rsp0_err   <= e0_d;
      rsp1_err   <= e1_d;
    end
  end

endmodule

// File: tb/tb_axi4_lite_read_arbiter.sv
// Bench for axi4_lite_read_arbiter: a cycle-count transaction model and a read-master stand-in.
// Directed scenarios are followed by a randomized run.
module tb_axi4_lite_read_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 8;

  logic          clk;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_addr, req1_addr;
  logic          req0_ready, req1_ready;
  logic          rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [DW-1:0] rsp_rdata;
  logic          read_start;
  logic [AW-1:0] read_addr;
  logic          read_busy;
  logic [DW-1:0] read_data;

  axi4_lite_read_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_err(rsp1_err),
    .rsp_rdata(rsp_rdata),
    .read_start(read_start), .read_addr(read_addr),
    .read_busy(read_busy), .read_data(read_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks, errors, cyc;

  // Model: time since the grant decides what the outputs must be.
  bit            m_active, m_resp, m_last, m_id, m_err;
  int            m_t;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_rdata, m_pend;

  // Read-master stand-in: busy for slv_lat cycles, starting the cycle after read_start.
  bit            go_next;
  int            rem, cur_lat, slv_lat;
  logic [DW-1:0] slv_data, pend_data;
  bit            hs0, hs1;

  // Event logs taken from the DUT pins
  int            g_cyc[$];
  bit            g_id[$];
  int            s_cyc[$];
  logic [AW-1:0] s_addr[$];
  int            r_cyc[$];
  bit            r_id[$];
  bit            r_err[$];
  logic [DW-1:0] r_data[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_cycle();
    bit            e_rdy0, e_rdy1, e_v0, e_v1, e_e0, e_e1, e_start;
    logic [AW-1:0] e_addr;
    logic [6:0]    e_ctl, a_ctl;
    e_rdy0 = 0; e_rdy1 = 0; e_v0 = 0; e_v1 = 0; e_e0 = 0; e_e1 = 0; e_start = 0;
    e_addr = '0;
    if (!rst_n) begin
      m_active = 0; m_resp = 0; m_last = 1; m_rdata = '0;
    end else if (m_active && m_resp) begin
      m_rdata  = m_pend;
      m_active = 0;
      m_resp   = 0;
      if (m_id) begin e_v1 = 1; e_e1 = m_err; end
      else      begin e_v0 = 1; e_e0 = m_err; end
    end else if (m_active) begin
      m_t++;
      if (m_t == 1) begin
        e_start = 1; e_addr = m_addr;
      end else if (!read_busy) begin
        m_resp = 1; m_pend = read_data; m_err = 0;
      end else if (m_t == int'(TMO) + 1) begin
        m_resp = 1; m_pend = '0; m_err = 1;
      end
    end else if (!read_busy && (req0_valid || req1_valid)) begin
      m_id     = req1_valid && (!req0_valid || !m_last);
      m_last   = m_id;
      m_addr   = m_id ? req1_addr : req0_addr;
      m_active = 1;
      m_t      = 0;
      e_rdy0   = !m_id;
      e_rdy1   = m_id;
    end
    e_ctl = {e_rdy0, e_rdy1, e_v0, e_v1, e_e0, e_e1, e_start};
    a_ctl = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, read_start};
    chk("ctl", 32'(a_ctl), 32'(e_ctl));
    chk("read_addr", read_addr, e_addr);
    chk("rsp_rdata", rsp_rdata, m_rdata);

    hs0 = req0_valid && req0_ready;
    hs1 = req1_valid && req1_ready;
    if (hs0) begin g_cyc.push_back(cyc); g_id.push_back(1'b0); end
    if (hs1) begin g_cyc.push_back(cyc); g_id.push_back(1'b1); end
    if (read_start) begin s_cyc.push_back(cyc); s_addr.push_back(read_addr); end
    if (rsp0_valid || rsp1_valid) begin
      r_cyc.push_back(cyc); r_id.push_back(rsp1_valid);
      r_err.push_back(rsp0_err | rsp1_err); r_data.push_back(rsp_rdata);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    model_cycle();
    @(posedge clk);
    #1;
    if (go_next) begin
      read_busy = 1'b1; rem = cur_lat; go_next = 0;
    end else if (read_busy) begin
      rem--;
      if (rem <= 0) begin read_busy = 1'b0; read_data = pend_data; end
    end
    if (read_start) begin go_next = 1; cur_lat = slv_lat; pend_data = slv_data; end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_grants(input int n, input int budget, input string name);
    int base = g_cyc.size();
    int k = 0;
    while (g_cyc.size() < base + n && k < budget) begin tick(); k++; end
    chk(name, g_cyc.size() - base, n);
  endtask

  task automatic drive_rand();
    if (!req0_valid || hs0) begin req0_valid = ($urandom_range(99) < 35); req0_addr = $urandom; end
    if (!req1_valid || hs1) begin req1_valid = ($urandom_range(99) < 35); req1_addr = $urandom; end
    slv_lat  = int'($urandom_range(11, 2));
    slv_data = $urandom;
  endtask

  int gb, sb, rb;

  initial begin
    rst_n = 0; req0_valid = 0; req1_valid = 0; req0_addr = '0; req1_addr = '0;
    read_busy = 0; read_data = '0;
    checks = 0; errors = 0; cyc = 0;
    go_next = 0; rem = 0; cur_lat = 2; slv_lat = 2; slv_data = '0; pend_data = '0;
    m_active = 0; m_resp = 0; m_last = 1; m_id = 0; m_err = 0; m_t = 0;
    m_addr = '0; m_rdata = '0; m_pend = '0; hs0 = 0; hs1 = 0;
    run(3);
    #1 rst_n = 1;

    // Contention straight out of reset: req0 first, then alternating
    gb = g_cyc.size(); sb = s_cyc.size();
    req0_addr = 32'h10; req1_addr = 32'h20; req0_valid = 1; req1_valid = 1;
    slv_lat = 2; slv_data = 32'h1234_5678;
    wait_grants(3, 40, "cont_grants");
    req0_valid = 0; req1_valid = 0;
    run(10);
    chk("cont_id0", 32'(g_id[gb]), 0);
    chk("cont_id1", 32'(g_id[gb+1]), 1);
    chk("cont_id2", 32'(g_id[gb+2]), 0);
    chk("cont_addr0", s_addr[sb], 32'h10);
    chk("cont_addr1", s_addr[sb+1], 32'h20);
    chk("cont_addr2", s_addr[sb+2], 32'h10);
    chk("cont_span", g_cyc[gb+2] - g_cyc[gb], 12);

    // Single read with an immediate slave
    gb = g_cyc.size(); sb = s_cyc.size(); rb = r_cyc.size();
    req0_addr = 32'h100; req0_valid = 1; slv_data = 32'hDEAD_BEEF; slv_lat = 2;
    wait_grants(1, 20, "single_grant");
    req0_valid = 0;
    run(8);
    chk("single_start_lat", s_cyc[sb] - g_cyc[gb], 1);
    chk("single_addr", s_addr[sb], 32'h100);
    chk("single_rsp_lat", r_cyc[rb] - g_cyc[gb], 5);
    chk("single_id", 32'(r_id[rb]), 0);
    chk("single_err", 32'(r_err[rb]), 0);
    chk("single_data", r_data[rb], 32'hDEAD_BEEF);

    // req1 alone, three back-to-back reads
    gb = g_cyc.size(); rb = r_cyc.size();
    req1_addr = 32'h41; req1_valid = 1; slv_data = 32'hA5A5_0041;
    wait_grants(3, 40, "solo_grants");
    req1_valid = 0;
    run(8);
    chk("solo_id", 32'({g_id[gb], g_id[gb+1], g_id[gb+2]}), 32'h7);
    chk("solo_gap1", g_cyc[gb+1] - g_cyc[gb], 6);
    chk("solo_gap2", g_cyc[gb+2] - g_cyc[gb+1], 6);
    chk("solo_rsps", r_cyc.size() - rb, 3);

    // Slow slave: busy drops on the last WAIT cycle before the timeout would fire
    gb = g_cyc.size(); rb = r_cyc.size();
    req1_addr = 32'h38; req1_valid = 1; slv_lat = 7; slv_data = 32'h0BAD_F00D;
    wait_grants(1, 20, "slow_grant");
    req1_valid = 0;
    run(14);
    chk("slow_rsp_lat", r_cyc[rb] - g_cyc[gb], 10);
    chk("slow_id", 32'(r_id[rb]), 1);
    chk("slow_err", 32'(r_err[rb]), 0);
    chk("slow_data", r_data[rb], 32'h0BAD_F00D);

    // Timeout: error after 8 WAIT cycles, no new grant while the master is still busy
    gb = g_cyc.size(); rb = r_cyc.size();
    req0_addr = 32'h39; req0_valid = 1; slv_lat = 22;
    wait_grants(1, 20, "tmo_grant");
    slv_lat = 2;
    wait_grants(1, 60, "tmo_regrant");
    req0_valid = 0;
    run(10);
    chk("tmo_rsp_lat", r_cyc[rb] - g_cyc[gb], 10);
    chk("tmo_id", 32'(r_id[rb]), 0);
    chk("tmo_err", 32'(r_err[rb]), 1);
    chk("tmo_data", r_data[rb], 32'h0);
    chk("tmo_regrant_gap", g_cyc[gb+1] - g_cyc[gb], 24);
    chk("tmo_second_err", 32'(r_err[rb+1]), 0);

    // Reset in the middle of WAIT
    req0_addr = 32'h40; req0_valid = 1; slv_lat = 6;
    wait_grants(1, 20, "rst_grant");
    req0_valid = 0;
    run(3);
    #1 rst_n = 0;
    #1;
    chk("rst_ctl", 32'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err,
                        read_start}), 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_raddr", read_addr, 0);
    tick();
    #1 rst_n = 1;
    gb = g_cyc.size(); rb = r_cyc.size();
    req0_addr = 32'h10; req1_addr = 32'h20; req0_valid = 1; req1_valid = 1; slv_lat = 2;
    wait_grants(1, 30, "rst_next_grant");
    chk("rst_next_id", 32'(g_id[gb]), 0);
    chk("rst_no_rsp", r_cyc.size() - rb, 0);
    req0_valid = 0; req1_valid = 0;
    run(10);

    // Randomized traffic with one reset partway through
    for (int i = 0; i < 3000; i++) begin
      drive_rand();
      if (i == 1500) begin
        #1 rst_n = 0;
        tick();
        #1 rst_n = 1;
      end else begin
        tick();
      end
    end
    req0_valid = 0; req1_valid = 0;
    run(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_lite_read_arbiter.md
AXI4_LITE_READ_ARBITER -- requirements
Module: axi4_lite_read_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning the address width of both requesters and the master port.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the read data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, meaning the maximum number of WAIT cycles before an error completion; 0 disables the timeout.
REQ-004 SHALL have clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have rst_n, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have req0_valid / req1_valid, input, 1 each, a requester has a pending read (0 = fetch, 1 = load).
REQ-007 SHALL have req0_addr / req1_addr, input, ADDR_WIDTH each, the read address.
REQ-008 SHALL have req0_ready / req1_ready, output, 1 each, the request is accepted this cycle.
REQ-009 SHALL have rsp0_valid / rsp1_valid, output, 1 each, a one-cycle completion pulse.
REQ-010 SHALL have rsp0_err / rsp1_err, output, 1 each, a timeout error qualifier, valid with rsp*_valid.
REQ-011 SHALL have rsp_rdata, output, DATA_WIDTH, the read data shared by both responses.
REQ-012 SHALL have read_start, output, 1, a start pulse to the AXI4-Lite read master.
REQ-013 SHALL have read_addr, output, ADDR_WIDTH, the address to the read master.
REQ-014 SHALL have read_busy, input, 1, the read master's transaction-in-progress flag.
REQ-015 SHALL have read_data, input, DATA_WIDTH, the read master's registered read data.

Function
REQ-016 SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP.
REQ-017 SHALL define the IDLE exit: with read_busy=0 and any reqN_valid=1, it grants one requester, pulses that reqN_ready combinationally in the same cycle, latches that address and ID, and goes to ISSUE.
REQ-018 SHALL remain in IDLE with no ready asserted while read_busy=1, even if requests are pending.
REQ-019 SHALL arbitrate round-robin: when both are valid, grant the requester not granted last; a single valid requester is always granted regardless of the pointer.
REQ-020 SHALL update the last-grant pointer only on a grant.
REQ-021 SHALL require requesters to hold valid and addr stable until ready; a valid deasserted before ready is a protocol violation and is not checked.
REQ-022 SHALL, in ISSUE, drive read_start=1 and read_addr=the latched address for exactly one cycle, then go to WAIT.
REQ-023 SHALL drive read_start=0 and read_addr=0 in every state other than ISSUE.
REQ-024 SHALL, in WAIT, go to RESP on the first cycle with read_busy=0, registering rsp_rdata<=read_data and err=0.
REQ-025 SHALL time out WAIT: a counter clears on entry and increments each WAIT cycle; when TIMEOUT_CYCLES≠0 and the count reaches TIMEOUT_CYCLES-1 with read_busy=1, go to RESP with rsp_rdata<=0 and err=1.
REQ-026 SHALL size the timeout counter to hold TIMEOUT_CYCLES-1 and never wrap.
REQ-027 SHALL, in RESP, pulse rspN_valid=1 for the latched ID only, with rspN_err=err, for one cycle, then go to IDLE.
REQ-028 SHALL, after a timeout, let the read master finish its transaction while the arbiter gates new grants per REQ-018; data from that late transaction is discarded.
REQ-029 SHALL hold rsp_rdata until the next RESP.
REQ-030 SHALL define latency: with ARREADY=1 and RVALID in the first WAIT_RDATA cycle of the master, ready in cycle 0 gives read_start in cycle 1 and rsp valid in cycle 5.
REQ-031 SHALL allow the next grant in the IDLE cycle immediately after RESP, giving back-to-back service at 6 cycles per read.
REQ-032 SHALL treat a request arriving while the FSM is not in IDLE as pending; it is served on the next IDLE entry.

Reset
REQ-033 SHALL, while rst_n=0, asynchronously force the state to IDLE and clear all outputs, rsp_rdata, the latched address/ID and the counter.
REQ-034 SHALL set the last-grant pointer on reset so that req0 wins the first contention.
REQ-035 SHALL abandon an in-flight transaction on reset mid-operation with no response pulse; requesters reissue.

Verification
REQ-036 SHALL cover a single read: req0 addr 0x100, slave returns 0xDEADBEEF immediately -> req0_ready in cycle 0, read_start+read_addr=0x100 in cycle 1, rsp0_valid with rdata 0xDEADBEEF and err=0 in cycle 5.
REQ-037 SHALL cover contention: both valid from reset, addr0 0x10 and addr1 0x20 -> grants in order req0, req1, req0; read_addr sequence 0x10, 0x20, 0x10.
REQ-038 SHALL cover a slow slave: ARREADY delayed 3 cycles and RVALID delayed 4 -> no response until read_busy falls; rsp1_valid one cycle after.
REQ-039 SHALL cover timeout: TIMEOUT_CYCLES=8, RVALID never asserted -> rsp0_valid and rsp0_err=1, rdata=0 after 8 WAIT cycles; no grant until read_busy=0.
REQ-040 SHALL cover reset mid-WAIT: rst_n low for 1 cycle -> all outputs 0 immediately, no rsp pulse, and the next contention is won by req0.
REQ-041 SHALL cover a single requester: req1 alone for 3 consecutive reads -> every one granted, back-to-back at 6-cycle spacing.
